// File: rtl/as_pack.sv
// Shared definitions for the Wishbone bus-protocol interfaces.
//   wbdSel              : byte-select width of the 64-bit data bus
//   bpi_timeout_default : default stb-to-ack watchdog limit, in cycles
//   bpi_state_t         : master bus-protocol FSM states
package as_pack;

  localparam int wbdSel              = 8;
  localparam int bpi_timeout_default = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } bpi_state_t;

endpackage

// File: rtl/as_bpi_wdt.sv
// Loadable down-counter used as a bus watchdog.
//   clk        : clock, posedge
//   rst_n      : synchronous active-low reset, clears the count
//   clear      : synchronous clear (priority over load)
//   load       : load load_value into the count
//   load_value : starting count; expiry happens load_value+1 enabled cycles later
//   enable     : count down while high
//   expired    : high while enabled with the count at zero
module as_bpi_wdt #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [width-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [width-1:0] count;

  // NOTE: sequential state is assigned with <= only, so every register
  // samples the pre-edge values of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - width'(1);
    end
  end

  assign expired = enable && (count == '0);

endmodule

// File: rtl/as_master_bpi.sv
// Wishbone classic master bus-protocol interface. Turns one single-beat
// core request into one Wishbone read or write cycle, waiting for the
// arbiter grant first and aborting with err_o if ack never arrives.
//   Core side : req_i, we_i, addr_i, dat_i, sel_i -> busy_o, done_o, err_o, dat_o
//   Bus side  : wbAddr_o, wbDat_o, wbWe_o, wbSel_o, wbStb_o, wbCyc_o,
//               wbDat_i, wbAck_i, gnt_i
//   clk_i / rst_i : clock and synchronous active-low reset
// All outputs are registered.
module as_master_bpi
  import as_pack::*;
#(
  parameter int addr_width     = 64,
  parameter int data_width     = 64,
  parameter int sel_width      = wbdSel,
  parameter int timeout_cycles = bpi_timeout_default
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [addr_width-1:0] addr_i,
  input  logic [data_width-1:0] dat_i,
  input  logic [sel_width-1:0]  sel_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [data_width-1:0] dat_o,
  output logic [addr_width-1:0] wbAddr_o,
  output logic [data_width-1:0] wbDat_o,
  input  logic [data_width-1:0] wbDat_i,
  output logic                  wbWe_o,
  output logic [sel_width-1:0]  wbSel_o,
  output logic                  wbStb_o,
  output logic                  wbCyc_o,
  input  logic                  wbAck_i,
  input  logic                  gnt_i
);

  // Watchdog is loaded with timeout_cycles-1 on grant so it reaches zero in
  // the timeout_cycles-th stb cycle.
  localparam int wdt_width = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam int wdt_start = (timeout_cycles > 0) ? timeout_cycles - 1 : 0;

  bpi_state_t state;
  logic       wdt_expired;
  logic       timeout_hit;

  as_bpi_wdt #(
    .width (wdt_width)
  ) u_wdt (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .clear      (state == DONE),
    .load       ((state == ARB) && gnt_i),
    .load_value (wdt_width'(wdt_start)),
    .enable     (state == XFER),
    .expired    (wdt_expired)
  );

  assign timeout_hit = (timeout_cycles != 0) && wdt_expired;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      dat_o    <= '0;
      wbAddr_o <= '0;
      wbDat_o  <= '0;
      wbWe_o   <= 1'b0;
      wbSel_o  <= '0;
      wbStb_o  <= 1'b0;
      wbCyc_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            // Bus-side copies hold the request stable for the whole cycle.
            wbAddr_o <= addr_i;
            wbDat_o  <= dat_i;
            wbWe_o   <= we_i;
            wbSel_o  <= sel_i;
            wbCyc_o  <= 1'b1;
            busy_o   <= 1'b1;
            state    <= ARB;
          end
        end
        ARB: begin
          if (gnt_i) begin
            wbStb_o <= 1'b1;
            state   <= XFER;
          end
        end
        XFER: begin
          // Ack is checked first so it wins over a simultaneous timeout.
          // A dropped grant here is a protocol violation and is ignored.
          if (wbAck_i) begin
            wbCyc_o <= 1'b0;
            wbStb_o <= 1'b0;
            if (!wbWe_o) dat_o <= wbDat_i;
            done_o  <= 1'b1;
            err_o   <= 1'b0;
            state   <= DONE;
          end else if (timeout_hit) begin
            wbCyc_o <= 1'b0;
            wbStb_o <= 1'b0;
            dat_o   <= '0;
            done_o  <= 1'b1;
            err_o   <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          err_o  <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_as_master_bpi.sv
// Directed self-checking bench for as_master_bpi (default parameters,
// timeout_cycles = 16). Inputs are driven and outputs sampled 1 ns after
// each rising edge.
module tb_as_master_bpi;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [63:0] addr_i;
  logic [63:0] dat_i;
  logic [7:0]  sel_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [63:0] dat_o;
  logic [63:0] wbAddr_o;
  logic [63:0] wbDat_o;
  logic [63:0] wbDat_i;
  logic        wbWe_o;
  logic [7:0]  wbSel_o;
  logic        wbStb_o;
  logic        wbCyc_o;
  logic        wbAck_i;
  logic        gnt_i;

  int checks = 0;
  int errors = 0;

  as_master_bpi dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .dat_i    (dat_i),
    .sel_i    (sel_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o),
    .dat_o    (dat_o),
    .wbAddr_o (wbAddr_o),
    .wbDat_o  (wbDat_o),
    .wbDat_i  (wbDat_i),
    .wbWe_o   (wbWe_o),
    .wbSel_o  (wbSel_o),
    .wbStb_o  (wbStb_o),
    .wbCyc_o  (wbCyc_o),
    .wbAck_i  (wbAck_i),
    .gnt_i    (gnt_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, busy_o, 0);
    check({tag, ".done"}, done_o, 0);
    check({tag, ".err"},  err_o, 0);
    check({tag, ".dat"},  dat_o, 0);
    check({tag, ".cyc"},  wbCyc_o, 0);
    check({tag, ".stb"},  wbStb_o, 0);
    check({tag, ".we"},   wbWe_o, 0);
    check({tag, ".adr"},  wbAddr_o, 0);
    check({tag, ".wdat"}, wbDat_o, 0);
    check({tag, ".sel"},  wbSel_o, 0);
  endtask

  initial begin
    rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; dat_i = '0;
    sel_i = '0; wbDat_i = '0; wbAck_i = 1'b0; gnt_i = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    rst_i = 1'b1;
    tick();

    // Zero-wait read.
    gnt_i = 1'b1; we_i = 1'b0; addr_i = 64'h1_0000; sel_i = 8'hFF;
    wbDat_i = 64'hDEAD_BEEF; req_i = 1'b1;
    tick();                                   // req accepted
    req_i = 1'b0;
    check("rd.cyc1", wbCyc_o, 1);
    check("rd.stb1", wbStb_o, 0);
    check("rd.busy1", busy_o, 1);
    check("rd.adr", wbAddr_o, 64'h1_0000);
    check("rd.we", wbWe_o, 0);
    tick();                                   // granted
    check("rd.cyc2", wbCyc_o, 1);
    check("rd.stb2", wbStb_o, 1);
    check("rd.done2", done_o, 0);
    wbAck_i = 1'b1;
    tick();                                   // ack sampled
    wbAck_i = 1'b0;
    check("rd.done3", done_o, 1);
    check("rd.err3", err_o, 0);
    check("rd.dat3", dat_o, 64'hDEAD_BEEF);
    check("rd.cyc3", wbCyc_o, 0);
    check("rd.stb3", wbStb_o, 0);
    check("rd.busy3", busy_o, 1);
    tick();
    check("rd.done4", done_o, 0);
    check("rd.busy4", busy_o, 0);

    // Write with ack in the third stb cycle; core-side data changes meanwhile.
    we_i = 1'b1; addr_i = 64'h20; sel_i = 8'h0F; dat_i = 64'h1234;
    wbDat_i = 64'h9999; req_i = 1'b1;
    tick();
    req_i = 1'b0; dat_i = 64'hFFFF; sel_i = 8'hF0; we_i = 1'b0;
    check("wr.we", wbWe_o, 1);
    tick();
    check("wr.stb1", wbStb_o, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("wr.stb_wait", wbStb_o, 1);
      check("wr.done_wait", done_o, 0);
      check("wr.wdat", wbDat_o, 64'h1234);
      check("wr.sel", wbSel_o, 8'h0F);
    end
    wbAck_i = 1'b1;
    tick();
    wbAck_i = 1'b0;
    check("wr.done", done_o, 1);
    check("wr.err", err_o, 0);
    check("wr.dat_held", dat_o, 64'hDEAD_BEEF);
    check("wr.cyc", wbCyc_o, 0);
    tick();

    // Arbitration stall longer than the timeout: no abort in ARB.
    gnt_i = 1'b0; we_i = 1'b0; addr_i = 64'h30; req_i = 1'b1;
    tick();
    req_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("arb.cyc", wbCyc_o, 1);
      check("arb.stb", wbStb_o, 0);
      check("arb.done", done_o, 0);
    end
    gnt_i = 1'b1;
    tick();
    check("arb.stb_gnt", wbStb_o, 1);
    wbAck_i = 1'b1; wbDat_i = 64'hCAFE;
    tick();
    wbAck_i = 1'b0;
    check("arb.done_end", done_o, 1);
    check("arb.err_end", err_o, 0);
    check("arb.dat_end", dat_o, 64'hCAFE);
    tick();

    // Timeout: slave never acks, stb high for exactly 16 cycles.
    addr_i = 64'h40; req_i = 1'b1;
    tick();
    req_i = 1'b0;
    tick();                                   // stb cycle 1
    check("to.stb1", wbStb_o, 1);
    for (int i = 2; i <= 16; i++) begin
      tick();
      check("to.stb_hold", wbStb_o, 1);
      check("to.done_hold", done_o, 0);
    end
    tick();
    check("to.stb_drop", wbStb_o, 0);
    check("to.cyc_drop", wbCyc_o, 0);
    check("to.done", done_o, 1);
    check("to.err", err_o, 1);
    check("to.dat", dat_o, 0);
    tick();
    check("to.busy_clr", busy_o, 0);

    // Ack in stb cycle 16 beats the timeout.
    addr_i = 64'h48; req_i = 1'b1; wbDat_i = 64'h5555;
    tick();
    req_i = 1'b0;
    tick();
    for (int i = 2; i <= 16; i++) tick();
    wbAck_i = 1'b1;
    tick();
    wbAck_i = 1'b0;
    check("tack.done", done_o, 1);
    check("tack.err", err_o, 0);
    check("tack.dat", dat_o, 64'h5555);
    tick();

    // Back-to-back: req and ack held high, one transaction every 4 cycles.
    addr_i = 64'h100; wbDat_i = 64'hABCD; wbAck_i = 1'b1; req_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 0) addr_i = 64'h200;
      if (i == 15) begin
        req_i = 1'b0;
        wbAck_i = 1'b0;
      end
      check("b2b.done", done_o, ((i % 4) == 2) ? 1 : 0);
      check("b2b.busy", busy_o, ((i % 4) == 3) ? 0 : 1);
      check("b2b.cyc", wbCyc_o, ((i % 4) < 2) ? 1 : 0);
      if (i == 1) check("b2b.adr_first", wbAddr_o, 64'h100);
      if (i == 4) check("b2b.adr_next", wbAddr_o, 64'h200);
    end
    check("b2b.dat", dat_o, 64'hABCD);
    tick();
    check("b2b.idle", busy_o, 0);

    // Reset in the middle of XFER.
    addr_i = 64'h300; req_i = 1'b1;
    tick();
    req_i = 1'b0;
    tick();
    tick();
    check("rst.stb_before", wbStb_o, 1);
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    check_all_zero("rst");
    tick();
    check("rst.done_after", done_o, 0);
    check("rst.cyc_after", wbCyc_o, 0);
    addr_i = 64'h308; wbDat_i = 64'h77; req_i = 1'b1;
    tick();
    req_i = 1'b0;
    check("rst.new_adr", wbAddr_o, 64'h308);
    tick();
    wbAck_i = 1'b1;
    tick();
    wbAck_i = 1'b0;
    check("rst.new_done", done_o, 1);
    check("rst.new_err", err_o, 0);
    check("rst.new_dat", dat_o, 64'h77);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
